// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring 32-bit divider (divw/divwu/modsw/moduw)
// Quotient/remainder plus ALU-style {lt,gt,eq} CR bits and overflow flag.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       cr,
  output logic             ov
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic             signed_q, neg1_q, neg2_q;
  logic             busy_q, done_q, ov_q;
  logic [WIDTH-1:0] result_q, remainder_q;
  logic [2:0]       cr_q;

  logic             exc;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_d, quot_d;
  logic [WIDTH-1:0] quot_fin, rem_fin;
  logic [2:0]       cr_fin;

  always_comb begin
    exc      = 1'b0;
    mag1     = src1;
    mag2     = src2;
    trial    = '0;
    fits     = 1'b0;
    rem_d    = rem_q;
    quot_d   = quot_q;
    quot_fin = quot_q;
    rem_fin  = rem_q;
    cr_fin   = 3'b000;

    exc = (src2 == '0) || (is_signed && (src1 == MIN_NEG) && (src2 == '1));
    if (is_signed && src1[WIDTH-1]) mag1 = -src1;
    if (is_signed && src2[WIDTH-1]) mag2 = -src2;

    // rem is always < divisor, so the shifted value needs only one extra bit
    // and the kept difference always fits back into WIDTH bits.
    trial  = {rem_q, quot_q[WIDTH-1]};
    fits   = (trial >= {1'b0, dvs_q});
    rem_d  = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    quot_d = {quot_q[WIDTH-2:0], fits};

    if (signed_q && (neg1_q ^ neg2_q)) quot_fin = -quot_q;
    if (signed_q && neg1_q)            rem_fin  = -rem_q;
    cr_fin = {quot_fin[WIDTH-1], ~quot_fin[WIDTH-1] & (|quot_fin), ~(|quot_fin)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ov_q        <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      cr_q        <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (exc) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              result_q    <= '0;
              remainder_q <= '0;
              cr_q        <= 3'b001;
              ov_q        <= 1'b1;
            end else begin
              state_q  <= RUN;
              quot_q   <= mag1;
              dvs_q    <= mag2;
              rem_q    <= '0;
              cnt_q    <= '0;
              signed_q <= is_signed;
              neg1_q   <= src1[WIDTH-1];
              neg2_q   <= src2[WIDTH-1];
            end
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_q <= FIX;
        end
        FIX: begin
          state_q     <= DONE;
          done_q      <= 1'b1;
          result_q    <= quot_fin;
          remainder_q <= rem_fin;
          cr_q        <= cr_fin;
          ov_q        <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign cr        = cr_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random checks of div_unit against an arithmetic model
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] src1, src2;
  logic        busy, done, ov;
  logic [31:0] result, remainder;
  logic [2:0]  cr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .src1(src1), .src2(src2), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .cr(cr), .ov(ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic [2:0] c, output bit o);
    if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      q = 0; r = 0; o = 1; c = 3'b001;
    end else begin
      o = 0;
      if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      c = {($signed(q) < 0), ($signed(q) > 0), (q == 0)};
    end
  endtask

  // Present operands for one cycle (cycle 0), then scramble them.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    src1 = a; src2 = b; is_signed = s; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input int lat);
    while (!done && cyc < 60) begin
      chk("busy_during_op", {31'b0, busy}, 32'd1);
      step();
    end
    chk("done_cycle", 32'(cyc), 32'(lat));
    chk("busy_at_done", {31'b0, busy}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] q, r;
    logic [2:0]  c;
    bit          o;
    model(a, b, s, q, r, c, o);
    launch(a, b, s);
    wait_done(o ? 1 : 34);
    chk("result", result, q);
    chk("remainder", remainder, r);
    chk("cr", {29'b0, cr}, {29'b0, c});
    chk("ov", {31'b0, ov}, {31'b0, o});
    step();
    chk("done_pulse_end", {31'b0, done}, 32'd0);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("result_hold", result, q);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; src1 = '0; src2 = '0;
    step(); step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_cr", {29'b0, cr}, 32'd0);
    chk("rst_ov", {31'b0, ov}, 32'd0);
    reset = 1'b0;
    step();

    run_op(32'd100, 32'd7, 1'b0);
    chk("100div7_q", result, 32'd14);
    chk("100div7_cr", {29'b0, cr}, 32'b010);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("m7div2_q", result, 32'hFFFF_FFFD);
    chk("m7div2_r", remainder, 32'hFFFF_FFFF);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("u_fff9div2_q", result, 32'h7FFF_FFFC);
    run_op(32'd5, 32'd0, 1'b0);
    chk("div0_cr", {29'b0, cr}, 32'b001);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("sovf_ov", {31'b0, ov}, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("u_min_r", remainder, 32'h8000_0000);
    run_op(32'h8000_0000, 32'd1, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);

    // Starts while busy (cycle 5 and the DONE cycle 34) must be dropped.
    launch(32'd100, 32'd7, 1'b0);
    while (cyc < 5) step();
    src1 = 32'd9; src2 = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 34) step();
    chk("busy_done_cyc34", {31'b0, done}, 32'd1);
    chk("busy_result", result, 32'd14);
    src1 = 32'd9; src2 = 32'd3; is_signed = 1'b0; start = 1'b1;
    step();
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    chk("result_held_35", result, 32'd14);
    step();
    start = 1'b0;
    while (!done && cyc < 90) step();
    chk("second_done_cycle", 32'(cyc), 32'd69);
    chk("second_result", result, 32'd3);
    step();

    // Reset mid-operation aborts with no done pulse.
    launch(32'd12345, 32'd67, 1'b0);
    while (cyc < 20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_cr", {29'b0, cr}, 32'd0);
    chk("abort_ov", {31'b0, ov}, 32'd0);
    while (cyc < 40) begin
      chk("abort_no_done", {31'b0, done}, 32'd0);
      step();
    end
    run_op(32'd9, 32'd3, 1'b0);

    // Reset and start in the same cycle: start is lost.
    reset = 1'b1; start = 1'b1; src1 = 32'd50; src2 = 32'd5; is_signed = 1'b0;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    chk("rst_start_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(1, 15));
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(a, b, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
